// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and iteration-counter width helper for divider_array
package divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/divider_lane.sv
// divider_lane: one restoring-division datapath, one quotient bit per step, optional round-to-nearest (DIVIDER_ROUND_EN)
module divider_lane #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             fin_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    logic [WIDTH-1:0] dsr_q, rem_q, quo_q, rem_d, quo_d, q_fin;
    logic [WIDTH:0]   trial;
    logic             no_borrow, zero;

    // One restoring step: quo_q shifts dividend bits out MSB first while quotient bits shift in
    always_comb begin
        trial     = {rem_q, quo_q[WIDTH-1]};
        no_borrow = trial >= {1'b0, dsr_q};
        rem_d     = no_borrow ? trial[WIDTH-1:0] - dsr_q : trial[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], no_borrow};
        zero      = dsr_q == '0;
`ifdef DIVIDER_ROUND_EN
        q_fin     = zero ? '1 : quo_d + {{(WIDTH-1){1'b0}}, {rem_d, 1'b0} >= {1'b0, dsr_q}};
`else
        q_fin     = zero ? '1 : quo_d;
`endif
    end

    // Working registers advance on load/step; visible results only change on the final step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            if (load_i) begin
                dsr_q <= divisor_i;
                rem_q <= '0;
                quo_q <= dividend_i;
            end else if (step_i) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
            end
            if (fin_i) begin
                quotient_o  <= q_fin;
                remainder_o <= rem_d;
                div_zero_o  <= zero;
            end
        end
    end

endmodule

// File: rtl/divider_array.sv
// divider_array: LANES lockstep restoring dividers sharing LANES/GROUP divisors, valid/ready handshakes (rounding via DIVIDER_ROUND_EN)
module divider_array
    import divider_pkg::*;
#(
    parameter int LANES = 6,
    parameter int WIDTH = 9,
    parameter int GROUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend  [LANES],
    input  logic [WIDTH-1:0] divisor   [LANES/GROUP],
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] quotient  [LANES],
    output logic [WIDTH-1:0] remainder [LANES],
    output logic [LANES-1:0] div_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    if (LANES % GROUP != 0) begin : g_bad_group
        $error("divider_array: LANES must be divisible by GROUP");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load, step, fin;

    // Next state, counter and handshake strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    fin     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and iteration counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = state_q != IDLE;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        divider_lane #(.WIDTH(WIDTH)) u_lane (
            .clk         (clk),
            .rst         (rst),
            .load_i      (load),
            .step_i      (step),
            .fin_i       (fin),
            .dividend_i  (dividend[i]),
            .divisor_i   (divisor[i/GROUP]),
            .quotient_o  (quotient[i]),
            .remainder_o (remainder[i]),
            .div_zero_o  (div_zero[i])
        );
    end

endmodule

// File: tb/tb_divider_array.sv
// tb_divider_array: table-driven scoreboard bench for divider_array plus backpressure, back-to-back and reset sequences
module tb_divider_array;

    localparam int L = 6;
    localparam int W = 9;
    localparam int N = 3;

    typedef struct packed {
        logic [L-1:0][W-1:0] a;
        logic [N-1:0][W-1:0] d;
        logic [L-1:0][W-1:0] q;
        logic [L-1:0][W-1:0] r;
        logic [L-1:0]        z;
    } vec_t;

    typedef struct packed {
        logic [L-1:0][W-1:0] q;
        logic [L-1:0][W-1:0] r;
        logic [L-1:0]        z;
    } exp_t;

    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [W-1:0] dividend [L];
    logic [W-1:0] divisor [N];
    logic [W-1:0] quotient [L];
    logic [W-1:0] remainder [L];
    logic [L-1:0] div_zero;
    logic in_ready, out_valid, busy;
    logic [L-1:0][W-1:0] qp, rp;

    int checks = 0, failures = 0;
    exp_t sbq[$];
    vec_t vt[8];

    always #5 clk = ~clk;

    divider_array #(.LANES(L), .WIDTH(W), .GROUP(2)) dut (
        .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
        .in_valid(in_valid), .in_ready(in_ready), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always_comb begin
        for (int l = 0; l < L; l++) begin
            qp[l] = quotient[l];
            rp[l] = remainder[l];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [L-1:0][W-1:0] a, input logic [N-1:0][W-1:0] d);
        vec_t v;
        int dd;
        v.a = a;
        v.d = d;
        for (int l = 0; l < L; l++) begin
            dd = int'(d[l/2]);
            if (dd == 0) begin
                v.q[l] = '1;
                v.r[l] = a[l];
                v.z[l] = 1'b1;
            end else begin
                v.q[l] = W'(int'(a[l]) / dd);
                v.r[l] = W'(int'(a[l]) % dd);
                v.z[l] = 1'b0;
`ifdef DIVIDER_ROUND_EN
                if (2 * int'(v.r[l]) >= dd) v.q[l] = v.q[l] + 1'b1;
`endif
            end
        end
        return v;
    endfunction

    function automatic exp_t exp_of(input vec_t v);
        exp_t e;
        e.q = v.q;
        e.r = v.r;
        e.z = v.z;
        return e;
    endfunction

    task automatic drive(input vec_t v);
        for (int l = 0; l < L; l++) dividend[l] = v.a[l];
        for (int k = 0; k < N; k++) divisor[k] = v.d[k];
    endtask

    task automatic compare_pop();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got output with no expected entry");
            return;
        end
        checks--;
        e = sbq.pop_front();
        for (int l = 0; l < L; l++) begin
            chk($sformatf("quotient[%0d]", l), 64'(qp[l]), 64'(e.q[l]));
            chk($sformatf("remainder[%0d]", l), 64'(rp[l]), 64'(e.r[l]));
        end
        chk("div_zero", 64'(div_zero), 64'(e.z));
    endtask

    task automatic consume();
        out_ready = 1;
        compare_pop();
        @(posedge clk); #1;
        out_ready = 0;
        chk("out_valid_after_consume", 64'(out_valid), 0);
        chk("in_ready_after_consume", 64'(in_ready), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0;
        while (!in_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("in_ready_wait", 64'(in_ready), 1);
        drive(v);
        in_valid = 1;
        sbq.push_back(exp_of(v));
        @(posedge clk); #1;
        in_valid = 0;
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("latency", 64'(cyc), 64'(W));
        consume();
    endtask

    initial begin
        vec_t v;
        logic ok;
        int t, nacc, nout, acc_t0, acc_t1, cyc;
        logic acc_now;

        vt[0] = '{a: {9'd50, 9'd18, 9'd1, 9'd41, 9'd20, 9'd64}, d: {9'd7, 9'd1, 9'd3},
`ifdef DIVIDER_ROUND_EN
                  q: {9'd7, 9'd3, 9'd1, 9'd41, 9'd7, 9'd21},
`else
                  q: {9'd7, 9'd2, 9'd1, 9'd41, 9'd6, 9'd21},
`endif
                  r: {9'd1, 9'd4, 9'd0, 9'd0, 9'd2, 9'd1}, z: 6'b000000};
        vt[1] = '{a: {9'd50, 9'd18, 9'd1, 9'd41, 9'd20, 9'd64}, d: {9'd7, 9'd0, 9'd3},
`ifdef DIVIDER_ROUND_EN
                  q: {9'd7, 9'd3, 9'd511, 9'd511, 9'd7, 9'd21},
`else
                  q: {9'd7, 9'd2, 9'd511, 9'd511, 9'd6, 9'd21},
`endif
                  r: {9'd1, 9'd4, 9'd1, 9'd41, 9'd2, 9'd1}, z: 6'b001100};
        vt[2] = '{a: {9'd0, 9'd511, 9'd510, 9'd511, 9'd511, 9'd0}, d: {9'd1, 9'd511, 9'd5},
`ifdef DIVIDER_ROUND_EN
                  q: {9'd0, 9'd511, 9'd1, 9'd1, 9'd102, 9'd0},
`else
                  q: {9'd0, 9'd511, 9'd0, 9'd1, 9'd102, 9'd0},
`endif
                  r: {9'd0, 9'd0, 9'd510, 9'd0, 9'd1, 9'd0}, z: 6'b000000};
        for (int i = 3; i < 8; i++) begin
            logic [L-1:0][W-1:0] a;
            logic [N-1:0][W-1:0] d;
            for (int l = 0; l < L; l++) a[l] = W'($urandom);
            for (int k = 0; k < N; k++) d[k] = (i == 7 && k == 2) ? '0 : W'($urandom_range(1, 511));
            vt[i] = model(a, d);
        end
        for (int l = 0; l < L; l++) dividend[l] = '0;
        for (int k = 0; k < N; k++) divisor[k] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_quotient", 64'(qp), 0);
        chk("rst_remainder", 64'(rp), 0);
        chk("rst_div_zero", 64'(div_zero), 0);

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // backpressure: results held while out_ready stays low, in_valid pulses ignored
        drive(vt[1]);
        in_valid = 1;
        sbq.push_back(exp_of(vt[1]));
        @(posedge clk); #1;
        in_valid = 0;
        drive(vt[2]);
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("bp_latency", 64'(cyc), 64'(W));
        ok = 1;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            ok &= (qp == vt[1].q) && (rp == vt[1].r) && (div_zero == vt[1].z)
                  && out_valid && !in_ready && busy;
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("bp_stable", 64'(ok), 1);
        consume();
        chk("bp_idle_busy", 64'(busy), 0);
        chk("bp_queue_empty", 64'(sbq.size()), 0);

        // back-to-back: in_valid and out_ready held high
        drive(vt[0]);
        in_valid = 1;
        out_ready = 1;
        nacc = 0; nout = 0; t = 0; acc_t0 = 0; acc_t1 = 0;
        while (nout < 2 && t < 80) begin
            acc_now = 0;
            if (in_valid && in_ready) begin
                if (nacc == 0) acc_t0 = t; else acc_t1 = t;
                sbq.push_back(exp_of(nacc == 0 ? vt[0] : vt[2]));
                nacc++;
                acc_now = 1;
            end
            if (out_valid) begin
                compare_pop();
                nout++;
            end
            @(posedge clk); #1;
            t++;
            if (acc_now) begin
                if (nacc == 1) drive(vt[2]); else in_valid = 0;
            end
        end
        in_valid = 0;
        out_ready = 0;
        chk("b2b_outputs", 64'(nout), 2);
        chk("b2b_gap", 64'(acc_t1 - acc_t0), 64'(W + 2));

        // reset mid-RUN after four steps
        drive(vt[0]);
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        #2;
        chk("mid_rst_in_ready", 64'(in_ready), 1);
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_quotient", 64'(qp), 0);
        chk("mid_rst_remainder", 64'(rp), 0);
        @(posedge clk); #1 rst = 0;
        sbq.delete();
        for (int l = 0; l < L; l++) v.a[l] = 9'd511;
        for (int k = 0; k < N; k++) v.d[k] = 9'd2;
        for (int l = 0; l < L; l++) begin
`ifdef DIVIDER_ROUND_EN
            v.q[l] = 9'd256;
`else
            v.q[l] = 9'd255;
`endif
            v.r[l] = 9'd1;
        end
        v.z = '0;
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
